// File: rtl/mips_cpu_muldiv.sv
// rtl/mips_cpu_muldiv.sv - iterative MIPS multiply/divide unit with HI/LO registers
module mips_cpu_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int            CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t state, state_next;

  logic          accept;
  logic          mt_hi;
  logic          mt_lo;
  logic [CW-1:0] cnt;

  // Latched per-operation context
  logic             is_div;
  logic             res_neg;
  logic             rem_neg;
  logic             div_zero;
  logic [WIDTH-1:0] opnd;     // multiplicand or divisor magnitude
  logic [WIDTH-1:0] acc_hi;   // product upper half or partial remainder
  logic [WIDTH-1:0] acc_lo;   // multiplier / dividend bits, becomes product low half or quotient

  // Operand conditioning in the accept cycle
  logic             signed_op;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  assign signed_op = ~op[0];
  assign a_neg     = signed_op & a[WIDTH-1];
  assign b_neg     = signed_op & b[WIDTH-1];
  assign a_mag     = a_neg ? -a : a;
  assign b_mag     = b_neg ? -b : b;

  // Iteration datapath: one multiplier bit or one quotient bit per cycle
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH-1:0] div_diff;
  logic             div_ge;

  assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
  // The shifted partial remainder needs one extra bit; the remainder itself
  // always stays below the divisor, so the stored copy fits WIDTH bits.
  assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
  assign div_ge    = (div_shift >= {1'b0, opnd});
  assign div_diff  = div_shift[WIDTH-1:0] - opnd;

  // Sign fix-up of the unsigned magnitude results
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign prod     = {acc_hi, acc_lo};
  assign prod_fix = res_neg ? -prod : prod;
  assign quot_fix = div_zero ? '1 : (res_neg ? -acc_lo : acc_lo);
  // Dividing by zero leaves |a| as the remainder; restoring the dividend's
  // sign yields the original a bit pattern, which is what HI must show.
  assign rem_fix  = rem_neg ? -acc_hi : acc_hi;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and control decode
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    mt_hi      = 1'b0;
    mt_lo      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (!op[2]) begin
            accept     = 1'b1;
            state_next = RUN;
          end else if (op[1:0] == 2'b00) begin
            mt_hi = 1'b1;
          end else if (op[1:0] == 2'b01) begin
            mt_lo = 1'b1;
          end
        end
      end
      RUN: begin
        if (cnt == LAST) begin
          state_next = FIX;
        end
      end
      FIX: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign busy = (state != IDLE);

  // Operand latch and per-cycle shift-add / restoring-divide step
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      is_div   <= 1'b0;
      res_neg  <= 1'b0;
      rem_neg  <= 1'b0;
      div_zero <= 1'b0;
      opnd     <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
    end else if (accept) begin
      cnt      <= '0;
      is_div   <= op[1];
      res_neg  <= a_neg ^ b_neg;
      rem_neg  <= a_neg;
      div_zero <= op[1] & (b == '0);
      opnd     <= b_mag;
      acc_hi   <= '0;
      acc_lo   <= a_mag;
    end else if (state == RUN) begin
      cnt <= cnt + 1'b1;
      if (is_div) begin
        acc_hi <= div_ge ? div_diff : div_shift[WIDTH-1:0];
        acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
      end else begin
        acc_hi <= mul_sum[WIDTH:1];
        acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
      end
    end
  end

  // Architectural HI/LO: direct moves in IDLE, atomic commit in FIX
  always_ff @(posedge clk) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
    end else if (mt_hi) begin
      hi <= a;
    end else if (mt_lo) begin
      lo <= a;
    end else if (state == FIX) begin
      if (is_div) begin
        hi <= rem_fix;
        lo <= quot_fix;
      end else begin
        hi <= prod_fix[2*WIDTH-1:WIDTH];
        lo <= prod_fix[WIDTH-1:0];
      end
    end
  end

  // Completion pulse, coincident with the HI/LO commit
  always_ff @(posedge clk) begin
    if (reset) begin
      done <= 1'b0;
    end else begin
      done <= (state == FIX);
    end
  end

endmodule
